// File: rtl/complex_unit.sv
// complex_unit: RV32M multiply/divide unit with a 4-state FSM.
// MUL/MULH/MULHSU/MULHU use a shift-add multiplier, one multiplier bit per cycle.
// DIV/DIVU/REM/REMU use a restoring divider, one quotient bit per cycle.
// Build macro COMPLEX_UNIT_FAST_MUL_EN swaps in a single-cycle registered multiplier.
// A request is accepted on edge E0. Divide-by-zero and signed overflow finish
// at E0. The iterative paths finish at E32. The fast multiplier finishes at E1.
// wb_valid_o is high for the single cycle that follows the finishing edge.
module complex_unit (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_i,
  input  logic        flush_i,
  input  logic        cu_valid_i,
  input  logic [2:0]  cu_opcode_i,
  input  logic [31:0] cu_operand1_i,
  input  logic [31:0] cu_operand2_i,
  output logic        busy_o,
  output logic [31:0] result_o,
  output logic        wb_valid_o
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;      // mul: partial product; div: remainder in [31:0]
  logic [63:0] opa_q, opa_d;      // mul: shifting multiplicand; div: divisor in [31:0]
  logic [31:0] opb_q, opb_d;      // mul: shifting multiplier; div: dividend becoming quotient
  logic        b_top_q, b_top_d;  // bit 32 of the extended multiplier (its negative weight)
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;

  // Request decode, evaluated on the raw inputs at the accepting edge.
  logic        is_div, div_signed, div_zero, div_ovf, special;
  logic        a_signed, b_signed;
  logic [31:0] special_res, dvd_mag, dvs_mag;

  assign is_div     = cu_opcode_i[2];
  assign div_signed = ~cu_opcode_i[0];
  assign div_zero   = (cu_operand2_i == 32'd0);
  assign div_ovf    = div_signed && (cu_operand1_i == 32'h8000_0000) &&
                      (cu_operand2_i == 32'hFFFF_FFFF);
  assign special    = is_div && (div_zero || div_ovf);
  // Divide by zero returns the dividend for REM/REMU and all ones for DIV/DIVU.
  // Signed overflow returns 0 for REM and 0x80000000 for DIV.
  assign special_res = cu_opcode_i[1] ? (div_zero ? cu_operand1_i : 32'd0)
                                      : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
  assign dvd_mag = (div_signed && cu_operand1_i[31]) ? (32'd0 - cu_operand1_i) : cu_operand1_i;
  assign dvs_mag = (div_signed && cu_operand2_i[31]) ? (32'd0 - cu_operand2_i) : cu_operand2_i;
  assign a_signed = (cu_opcode_i[1:0] == 2'b01) || (cu_opcode_i[1:0] == 2'b10);
  assign b_signed = (cu_opcode_i[1:0] == 2'b01);

  logic last_iter;
  assign last_iter = (cnt_q == 6'd31);

  // Restoring divide step: shift in the next dividend bit, subtract the divisor if it fits.
  logic [32:0] div_shift, div_diff;
  logic        div_fits;
  logic [31:0] rem_next, quo_next, quo_fin, rem_fin, div_res;
  assign div_shift = {acc_q[31:0], opb_q[31]};
  assign div_diff  = div_shift - {1'b0, opa_q[31:0]};
  assign div_fits  = ~div_diff[32];
  assign rem_next  = div_fits ? div_diff[31:0] : div_shift[31:0];
  assign quo_next  = {opb_q[30:0], div_fits};
  assign quo_fin   = neg_quo_q ? (32'd0 - quo_next) : quo_next;
  assign rem_fin   = neg_rem_q ? (32'd0 - rem_next) : rem_next;
  assign div_res   = op_q[1] ? rem_fin : quo_fin;

`ifdef COMPLEX_UNIT_FAST_MUL_EN
  // The low 64 bits of the 33x33 signed product equal the 64x64 product of the extended operands.
  logic [63:0] fast_prod;
  assign fast_prod = opa_q * {{32{b_top_q}}, opb_q};
`else
  // The multiplier is b[31:0] - b_top*2^32. The final step subtracts the multiplicand
  // shifted by 32, which is what the shift register holds after the 32nd step.
  logic [63:0] mul_acc_next, mul_a_next, mul_final;
  logic [31:0] mul_b_next;
  assign mul_acc_next = acc_q + (opb_q[0] ? opa_q : 64'd0);
  assign mul_a_next   = {opa_q[62:0], 1'b0};
  assign mul_b_next   = {1'b0, opb_q[31:1]};
  assign mul_final    = mul_acc_next - (b_top_q ? mul_a_next : 64'd0);
`endif

  // State register.
  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (cu_valid_i) state_d = special ? StDone : (is_div ? StDiv : StMul);
`ifdef COMPLEX_UNIT_FAST_MUL_EN
        StMul:  state_d = StDone;
`else
        StMul:  if (last_iter) state_d = StDone;
`endif
        StDiv:  if (last_iter) state_d = StDone;
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next state: latch the request in IDLE, then iterate in MUL/DIV.
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    b_top_d   = b_top_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    if (flush_i) begin
      cnt_d = 6'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cu_valid_i) begin
            op_d  = cu_opcode_i;
            cnt_d = 6'd0;
            acc_d = 64'd0;
            if (!is_div) begin
              opa_d   = {{32{a_signed & cu_operand1_i[31]}}, cu_operand1_i};
              opb_d   = cu_operand2_i;
              b_top_d = b_signed & cu_operand2_i[31];
            end else begin
              opa_d     = {32'd0, dvs_mag};
              opb_d     = dvd_mag;
              neg_quo_d = div_signed & (cu_operand1_i[31] ^ cu_operand2_i[31]);
              neg_rem_d = div_signed & cu_operand1_i[31];
              if (special) result_d = special_res;
            end
          end
        end
        StMul: begin
`ifdef COMPLEX_UNIT_FAST_MUL_EN
          acc_d    = fast_prod;
          result_d = (op_q == 3'b000) ? fast_prod[31:0] : fast_prod[63:32];
`else
          acc_d = mul_acc_next;
          opa_d = mul_a_next;
          opb_d = mul_b_next;
          cnt_d = cnt_q + 6'd1;
          if (last_iter) begin
            acc_d    = mul_final;
            cnt_d    = 6'd0;
            result_d = (op_q == 3'b000) ? mul_final[31:0] : mul_final[63:32];
          end
`endif
        end
        StDiv: begin
          acc_d = {32'd0, rem_next};
          opb_d = quo_next;
          cnt_d = cnt_q + 6'd1;
          if (last_iter) begin
            cnt_d    = 6'd0;
            result_d = div_res;
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      cnt_q     <= 6'd0;
      op_q      <= 3'd0;
      acc_q     <= 64'd0;
      opa_q     <= 64'd0;
      opb_q     <= 32'd0;
      b_top_q   <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      b_top_q   <= b_top_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  // Outputs decoded from state.
  always_comb begin
    busy_o     = (state_q != StIdle);
    wb_valid_o = (state_q == StDone);
    result_o   = result_q;
  end

endmodule

// File: tb/tb_complex_unit.sv
// tb_complex_unit: directed and table-driven vectors plus randomized ops for complex_unit.
// The reference model uses 64-bit integer arithmetic.
module tb_complex_unit;

`ifdef COMPLEX_UNIT_FAST_MUL_EN
  localparam int LatMul = 1;
`else
  localparam int LatMul = 32;
`endif
  localparam int LatDiv = 32;
  localparam int LatSpc = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        busy;
  logic [31:0] result;
  logic        wb_valid;

  int errors = 0;
  int checks = 0;

  complex_unit dut (
    .cpu_clk_i    (clk),
    .cpu_rst_i    (rst),
    .flush_i      (flush),
    .cu_valid_i   (valid),
    .cu_opcode_i  (opcode),
    .cu_operand1_i(op1),
    .cu_operand2_i(op2),
    .busy_o       (busy),
    .result_o     (result),
    .wb_valid_o   (wb_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns 1ns after the accepting edge E0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    valid  = 1'b1;
    opcode = op;
    op1    = a;
    op2    = b;
    step();
    valid = 1'b0;
  endtask

  // Observe from edge k0 until one cycle after the strobe, or until the budget runs out.
  task automatic wait_done(input int k0, output int lat, output int pulses,
                           output logic [31:0] res);
    lat    = -1;
    pulses = 0;
    res    = 32'd0;
    for (int k = k0; k <= 45; k++) begin
      if (wb_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          res = result;
        end
      end else if (lat >= 0) begin
        break;
      end
      step();
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    logic            ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    up  = 0;
    case (op)
      3'd0: begin p = sa * sb;          return p[31:0];  end
      3'd1: begin p = sa * sb;          return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub;         return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub;
        return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub;
        return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return LatMul;
    if (b == 0) return LatSpc;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LatSpc;
    return LatDiv;
  endfunction

  vec_t        vecs[$];
  int          lat, pulses, flush_k;
  logic [31:0] res, r_before;

  initial begin
    vecs.push_back('{"mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LatMul});
    vecs.push_back('{"div_neg7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LatDiv});
    vecs.push_back('{"rem_neg7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LatDiv});
    vecs.push_back('{"divu_by0", 3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, LatSpc});
    vecs.push_back('{"rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LatSpc});
    vecs.push_back('{"div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LatSpc});
    vecs.push_back('{"remu_by0", 3'd7, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, LatSpc});
    vecs.push_back('{"mul_3x4", 3'd0, 32'd3, 32'd4, 32'h0000_000C, LatMul});
    vecs.push_back('{"mulh_m1m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, LatMul});
    vecs.push_back('{"mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LatMul});
    vecs.push_back('{"divu_100_7", 3'd5, 32'd100, 32'd7, 32'h0000_000E, LatDiv});
    vecs.push_back('{"remu_100_7", 3'd7, 32'd100, 32'd7, 32'h0000_0002, LatDiv});

    // Reset state.
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wb", {31'd0, wb_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Table vectors; each op is issued immediately after the previous one completes.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat, pulses, res);
      check({vecs[i].name, "_res"}, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_pulses"}, pulses, 1);
      check({vecs[i].name, "_held"}, result, vecs[i].exp);
    end

    // A second request during a DIV is ignored.
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (4) step();
    valid = 1'b1; opcode = 3'd0; op1 = 32'd5; op2 = 32'd6;
    step();
    valid = 1'b0;
    check("ignore_busy", {31'd0, busy}, 32'd1);
    wait_done(5, lat, pulses, res);
    check("ignore_res", res, 32'hFFFF_FFFD);
    check("ignore_pulses", pulses, 1);
    check("ignore_lat", lat, LatDiv);

    // Flush mid-MULH. The fast build finishes at E1, so the flush lands on that edge instead.
    flush_k  = (LatMul == 1) ? 1 : 10;
    r_before = result;
    pulses   = 0;
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int k = 0; k < flush_k - 1; k++) begin
      if (wb_valid) pulses++;
      step();
    end
    if (wb_valid) pulses++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      if (wb_valid) pulses++;
      step();
    end
    check("flush_pulses", pulses, 0);
    check("flush_result_kept", result, r_before);
    issue(3'd0, 32'd3, 32'd4);
    wait_done(0, lat, pulses, res);
    check("post_flush_mul", res, 32'h0000_000C);
    check("post_flush_lat", lat, LatMul);

    // A flush coincident with a request drops the request.
    flush = 1'b1;
    issue(3'd5, 32'd9, 32'd2);
    flush = 1'b0;
    check("flush_accept_busy", {31'd0, busy}, 32'd0);

    // A flush on the finishing edge suppresses the strobe and keeps result_o.
    r_before = result;
    issue(3'd5, 32'h55, 32'd3);
    repeat (LatDiv - 1) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_last_wb", {31'd0, wb_valid}, 32'd0);
    check("flush_last_busy", {31'd0, busy}, 32'd0);
    check("flush_last_result", result, r_before);

    // An asynchronous reset mid-DIVU abandons the operation.
    issue(3'd5, 32'd1000, 32'd3);
    repeat (19) step();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_wb", {31'd0, wb_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    step();
    #2 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (wb_valid) pulses++;
    end
    check("arst_pulses", pulses, 0);
    issue(3'd5, 32'd100, 32'd7);
    wait_done(0, lat, pulses, res);
    check("arst_divu", res, 32'h0000_000E);
    check("arst_divu_lat", lat, LatDiv);

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 20); end
        3: rb = 32'd0 - 32'($urandom_range(1, 20));
        default: ;
      endcase
      issue(rop, ra, rb);
      wait_done(0, lat, pulses, res);
      check($sformatf("rand%0d_op%0d_%h_%h", n, rop, ra, rb), res, ref_model(rop, ra, rb));
      check($sformatf("rand%0d_lat", n), lat, ref_lat(rop, ra, rb));
      check($sformatf("rand%0d_pulses", n), pulses, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complex_unit.md
COMPLEX_UNIT -- requirements
Module: complex_unit

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits.
REQ-002 cpu_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 cpu_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 flush_i  in  1  synchronous pipeline flush; aborts in-flight operation.
REQ-005 cu_valid_i  in  1  request strobe from memory scheduler, one cycle per request.
REQ-006 cu_opcode_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 cu_operand1_i  in  32  rs1 value (multiplicand / dividend).
REQ-008 cu_operand2_i  in  32  rs2 value (multiplier / divisor).
REQ-009 busy_o  out  1  high while an operation is in flight (state != IDLE).
REQ-010 result_o  out  32  result register, valid while wb_valid_o high, held afterwards.
REQ-011 wb_valid_o  out  1  single-cycle completion strobe.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE with a 6-bit iteration counter.
REQ-013 SHALL accept a request only when cu_valid_i=1, flush_i=0 and state=IDLE; opcode and operands latched at that edge (E0); cu_valid_i in any other state SHALL be ignored.
REQ-014 IDLE->MUL if opcode[2]=0; IDLE->DIV if opcode[2]=1 and not a special case (REQ-017/018); IDLE->DONE directly for special cases.
REQ-015 MUL (iterative): shift-add on 33-bit sign/zero-extended operands (MULH/MULHSU sign-extend per RV32M, MULHU zero-extends), one bit per cycle, 32 iterations; MUL returns product[31:0], others product[63:32].
REQ-016 DIV: restoring division on operand magnitudes (signed ops) or raw values (unsigned ops), one quotient bit per cycle, 32 iterations; quotient negated if operand signs differ (DIV), remainder takes dividend sign (REM).
REQ-017 Divisor zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
REQ-018 Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF): DIV result 0x80000000; REM result 0x00000000.
REQ-019 After final iteration state SHALL move to DONE with result_o loaded; in DONE wb_valid_o=1 for exactly one cycle, then IDLE.
REQ-020 Latency (iterative paths): wb_valid_o high in cycle E33..E34; special-case divides: high in cycle E1..E2.
REQ-021 busy_o SHALL be combinationally (state != IDLE); a new request SHALL be accepted in the cycle after wb_valid_o (back-to-back throughput one op per 34 cycles).
REQ-022 flush_i=1 SHALL force state IDLE, wb_valid_o 0, counter 0 at next edge, including a flush coincident with DONE (strobe suppressed) or with cu_valid_i (request dropped); result_o unchanged.
REQ-023 result_o SHALL change only on entry to DONE.

Reset
REQ-024 cpu_rst_i=1 SHALL asynchronously set state IDLE, busy_o 0, wb_valid_o 0, result_o 0x00000000, counter 0, internal operand/accumulator registers 0.
REQ-025 Reset asserted mid-operation SHALL abandon it with no wb_valid_o pulse; first request after deassertion SHALL behave as from power-up.

Configuration
REQ-026 Macro COMPLEX_UNIT_FAST_MUL_EN: defined -> MUL state uses a single-cycle 33x33 signed product, registered, wb_valid_o high in cycle E2..E3; undefined -> iterative multiplier of REQ-015, latency per REQ-020. Divider identical in both builds.

Verification
REQ-027 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result_o 0xFFFFFFFE, wb_valid_o one cycle at E33 (E2 with COMPLEX_UNIT_FAST_MUL_EN).
REQ-028 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; each at E33.
REQ-029 DIVU 0x12345678 / 0 -> 0xFFFFFFFF at E1; REM 0x80000000 / 0xFFFFFFFF -> 0x00000000 at E1.
REQ-030 Second cu_valid_i at E5 during a DIV -> ignored, busy_o=1, only one wb_valid_o pulse.
REQ-031 flush_i at E10 of MULH -> busy_o 0 at E11, no wb_valid_o; new MUL 3x4 at E12 -> 0x0000000C.
REQ-032 cpu_rst_i pulsed at E20 of DIVU -> outputs zero immediately, no completion; subsequent DIVU 100/7 -> 0x0000000E.
